// File: rtl/door_1315_pkg.sv
// Shared types and default constants for the garage-door plant model.
package door_1315_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RISING   = 2'd1,
        ST_LOWERING = 2'd2,
        ST_FAULT    = 2'd3
    } plant_state_t;

    localparam int DOOR_POS_MAX  = 32'd100;
    localparam int DOOR_TICK_DIV = 32'd1000;

    // Bits needed to hold positions 0..pos_max
    function automatic int pos_width(input int pos_max);
        return (pos_max < 32'd1) ? 32'd1 : $clog2(pos_max + 32'd1);
    endfunction

endpackage

// File: rtl/door_plant_1315_if.sv
// Motor command / sensor bundle between the door controller (master) and the plant (slave).
interface door_plant_1315_if #(
    parameter int PW = 32'd7
);
    logic          motorleft;
    logic          motorright;
    logic          obstacle_req;
    logic          sensortop;
    logic          sensorbottom;
    logic          lightbarrier;
    logic          moving;
    logic          fault;
    logic [PW-1:0] position;

    modport master (
        output motorleft, motorright, obstacle_req,
        input  sensortop, sensorbottom, lightbarrier, moving, fault, position
    );

    modport slave (
        input  motorleft, motorright, obstacle_req,
        output sensortop, sensorbottom, lightbarrier, moving, fault, position
    );
endinterface

// File: rtl/door_tick_div.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled, o_tick flags the last count of each period.
module door_tick_div #(
    parameter int TICK_DIV = 32'd1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int            CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 32'd1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    // Next count: a clear or disable discards any partial period
    always_comb begin
        w_cnt_next = CNT_ZERO;
        if (i_clr || !i_en) begin
            w_cnt_next = CNT_ZERO;
        end else if (r_cnt == CNT_LAST) begin
            w_cnt_next = CNT_ZERO;
        end else begin
            w_cnt_next = r_cnt + CNT_ONE;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= CNT_ZERO;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_tick = i_en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/door_plant_1315.sv
// Garage-door plant: motor-driven position counter, limit sensors and synchronized light barrier.
// Optional macro DOOR_PLANT_FAULT_EN adds a sticky FAULT state (both motors / limit drive).
module door_plant_1315
    import door_1315_pkg::*;
#(
    parameter int POS_MAX   = DOOR_POS_MAX,
    parameter int TICK_DIV  = DOOR_TICK_DIV,
    parameter int START_POS = 32'd0
) (
    input logic              clk,
    input logic              rst_n,
    door_plant_1315_if.slave bus
);
    localparam int            PW        = pos_width(POS_MAX);
    localparam logic [PW-1:0] POS_TOP   = PW'(POS_MAX);
    localparam logic [PW-1:0] POS_START = PW'(START_POS);
    localparam logic [PW-1:0] POS_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] POS_ONE   = PW'(32'd1);

    plant_state_t  r_state;
    plant_state_t  w_cmd;
    plant_state_t  w_next;
    logic [PW-1:0] r_pos;
    logic [PW-1:0] w_pos_next;
    logic          r_moving;
    logic          r_fault;
    logic          w_fault_next;
    logic          r_sync1;
    logic          r_sync2;
    logic          w_en;
    logic          w_clr;
    logic          w_tick;
    logic          w_at_top;
    logic          w_at_bot;
    logic          w_blocked;
    logic          w_step;

    assign w_at_top  = (r_pos == POS_TOP);
    assign w_at_bot  = (r_pos == POS_ZERO);
    assign w_en      = (r_state == ST_RISING) || (r_state == ST_LOWERING);
    assign w_clr     = (w_next != r_state);
    // A completed period against the limit in the driving direction produces no step
    assign w_blocked = ((r_state == ST_RISING) && w_at_top) || ((r_state == ST_LOWERING) && w_at_bot);
    assign w_step    = w_tick && !w_blocked;

    door_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .o_tick (w_tick)
    );

    // Direction requested by the motor inputs
    always_comb begin
        w_cmd = ST_IDLE;
        case ({bus.motorleft, bus.motorright})
            2'b10:   w_cmd = ST_RISING;
            2'b01:   w_cmd = ST_LOWERING;
`ifdef DOOR_PLANT_FAULT_EN
            2'b11:   w_cmd = ST_FAULT;
`else
            2'b11:   w_cmd = ST_IDLE;
`endif
            default: w_cmd = ST_IDLE;
        endcase
    end

    // Next state; FAULT is absorbing until rst_n when compiled in
    always_comb begin
        w_next       = ST_IDLE;
        w_fault_next = 1'b0;
`ifdef DOOR_PLANT_FAULT_EN
        if ((r_state == ST_FAULT) || (w_tick && w_blocked)) begin
            w_next = ST_FAULT;
        end else begin
            w_next = w_cmd;
        end
        w_fault_next = (w_next == ST_FAULT);
`else
        w_next       = w_cmd;
        w_fault_next = 1'b0;
`endif
    end

    // Position update on each unblocked step
    always_comb begin
        w_pos_next = r_pos;
        if (w_step && (r_state == ST_RISING)) begin
            w_pos_next = r_pos + POS_ONE;
        end else if (w_step && (r_state == ST_LOWERING)) begin
            w_pos_next = r_pos - POS_ONE;
        end else begin
            w_pos_next = r_pos;
        end
    end

    // State, position and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_pos    <= POS_START;
            r_moving <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_pos    <= w_pos_next;
            r_moving <= w_step;
            r_fault  <= w_fault_next;
        end
    end

    // Two-flop synchronizer for the asynchronous obstacle input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.obstacle_req;
            r_sync2 <= r_sync1;
        end
    end

    assign bus.position     = r_pos;
    assign bus.sensortop    = w_at_top;
    assign bus.sensorbottom = w_at_bot;
    assign bus.moving       = r_moving;
    assign bus.fault        = r_fault;
    assign bus.lightbarrier = r_sync2;

endmodule

// File: tb/tb_door_plant_1315.sv
// Self-checking bench for door_plant_1315 (POS_MAX=4, TICK_DIV=3, START_POS=0): vector table,
// corner-case sequences and randomized motor traffic against an edge-counting reference model.
module tb_door_plant_1315;
    localparam int PM = 4;
    localparam int TD = 3;
    localparam int PW = 3;
`ifdef DOOR_PLANT_FAULT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    door_plant_1315_if #(.PW(PW)) bus ();

    door_plant_1315 #(
        .POS_MAX   (PM),
        .TICK_DIV  (TD),
        .START_POS (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a step is attempted every TD-th edge after the motor direction was taken up
    int edge_n = 0;
    int m_since = 0;
    int m_dir = 0;
    int m_pos = 0;
    bit m_fault = 1'b0;
    bit m_mov = 1'b0;
    bit m_o1 = 1'b0;
    bit m_lb = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_dir = 0; m_since = edge_n;
        m_fault = 1'b0; m_mov = 1'b0; m_o1 = 1'b0; m_lb = 1'b0;
    endtask

    task automatic model_edge(input bit l, input bit r, input bit ob);
        int tgt;
        int nd;
        edge_n++;
        m_mov = 1'b0;
        if (!m_fault && m_dir != 0 && ((edge_n - m_since) % TD) == 0) begin
            tgt = m_pos + m_dir;
            if (tgt >= 0 && tgt <= PM) begin
                m_pos = tgt;
                m_mov = 1'b1;
            end else if (FEAT) begin
                m_fault = 1'b1;
            end
        end
        if (m_fault) nd = 0;
        else if (l && r) begin nd = 0; if (FEAT) m_fault = 1'b1; end
        else if (l) nd = 1;
        else if (r) nd = -1;
        else nd = 0;
        if (nd != m_dir) m_since = edge_n;
        m_dir = nd;
        m_lb = m_o1;
        m_o1 = ob;
    endtask

    task automatic compare_model();
        chk("position", int'(bus.position), m_pos);
        chk("sensortop", int'(bus.sensortop), int'(m_pos == PM));
        chk("sensorbottom", int'(bus.sensorbottom), int'(m_pos == 0));
        chk("moving", int'(bus.moving), int'(m_mov));
        chk("lightbarrier", int'(bus.lightbarrier), int'(m_lb));
        chk("fault", int'(bus.fault), int'(m_fault));
    endtask

    task automatic drive(input bit l, input bit r, input bit ob);
        bus.motorleft = l; bus.motorright = r; bus.obstacle_req = ob;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_edge(bus.motorleft, bus.motorright, bus.obstacle_req);
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        model_reset();
        compare_model();
        chk("reset_pos", int'(bus.position), 0);
        chk("reset_bottom", int'(bus.sensorbottom), 1);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit l; bit r; bit ob; int n;
        int pos; bit top; bit bot; bit mov; bit lb;
    } vec_t;
    vec_t tbl[15];

    int lb_cnt;
    int pos_before;
    int k;
    bit rl, rr;

    initial begin
        // Hand-derived travel sequence from reset (edges numbered from 0)
        tbl[0]  = '{1, 0, 0, 3, 0, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 1, 0, 0, 1, 0};
        tbl[2]  = '{1, 0, 0, 3, 2, 0, 0, 1, 0};
        tbl[3]  = '{1, 0, 0, 6, 4, 1, 0, 1, 0};
        tbl[4]  = '{1, 0, 0, 1, 4, 1, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 3, 4, 1, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 1, 3, 0, 0, 1, 0};
        tbl[7]  = '{1, 0, 0, 3, 3, 0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 1, 4, 1, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 2, 4, 1, 0, 0, 0};
        tbl[10] = '{0, 1, 0, 7, 2, 0, 0, 1, 0};
        tbl[11] = '{0, 1, 0, 6, 0, 0, 1, 1, 0};
        tbl[12] = '{0, 0, 1, 2, 0, 0, 1, 0, 1};
        tbl[13] = '{0, 0, 0, 1, 0, 0, 1, 0, 1};
        tbl[14] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};

        drive(1'b0, 1'b0, 1'b0);
        do_reset();
        chk("reset_top", int'(bus.sensortop), 0);
        chk("reset_fault", int'(bus.fault), 0);

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].l, tbl[i].r, tbl[i].ob);
            repeat (tbl[i].n) cyc();
            chk($sformatf("tbl%0d_pos", i), int'(bus.position), tbl[i].pos);
            chk($sformatf("tbl%0d_top", i), int'(bus.sensortop), int'(tbl[i].top));
            chk($sformatf("tbl%0d_bot", i), int'(bus.sensorbottom), int'(tbl[i].bot));
            chk($sformatf("tbl%0d_mov", i), int'(bus.moving), int'(tbl[i].mov));
            chk($sformatf("tbl%0d_lb", i), int'(bus.lightbarrier), int'(tbl[i].lb));
        end

        // Obstacle pulse: five cycles of light barrier, position untouched
        pos_before = int'(bus.position);
        lb_cnt = 0;
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin cyc(); lb_cnt += int'(bus.lightbarrier); end
        drive(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin cyc(); lb_cnt += int'(bus.lightbarrier); end
        chk("lb_pulse_len", lb_cnt, 5);
        chk("lb_pos_same", int'(bus.position), pos_before);

        // Both motors: frozen position, fault only when compiled in, sticky after release
        drive(1'b1, 1'b0, 1'b0);
        repeat (4) cyc();
        chk("pre_both_pos", int'(bus.position), 1);
        drive(1'b1, 1'b1, 1'b0);
        cyc();
        chk("both_fault_next_edge", int'(bus.fault), int'(FEAT));
        repeat (5) cyc();
        chk("both_pos_frozen", int'(bus.position), 1);
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) cyc();
        chk("both_fault_sticky", int'(bus.fault), int'(FEAT));
        do_reset();
        chk("fault_cleared", int'(bus.fault), 0);

        // Limit drive at position 0: three cycles faults, two cycles does not
        drive(1'b0, 1'b1, 1'b0);
        repeat (3) cyc();
        drive(1'b0, 1'b0, 1'b0);
        cyc();
        chk("limit3_fault", int'(bus.fault), int'(FEAT));
        do_reset();
        drive(1'b0, 1'b1, 1'b0);
        repeat (2) cyc();
        drive(1'b0, 1'b0, 1'b0);
        repeat (3) cyc();
        chk("limit2_nofault", int'(bus.fault), 0);

        // Reset mid-travel returns to the start position
        drive(1'b1, 1'b0, 1'b0);
        repeat (7) cyc();
        chk("mid_travel_pos", int'(bus.position), 2);
        do_reset();
        chk("mid_travel_reset", int'(bus.position), 0);

        // Randomized motor and obstacle traffic with periodic resets
        rl = 1'b0; rr = 1'b0;
        for (int i = 0; i < 2400; i++) begin
            if ((i % 400) == 399) do_reset();
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, 9);
                rl = (k < 4) || (k == 9);
                rr = (k >= 4 && k < 8) || (k == 9);
            end
            drive(rl, rr, ($urandom_range(0, 3) == 0));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
